// File: rtl/uart_arb_defs.sv
// Shared definitions for the UART transmitter arbiter: FSM encodings, default
// frame width and a constant-safe clog2.
package uart_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } state_t;

  localparam int DBIT_DEFAULT = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or above
// pointer, wrapping modulo N_REQ.
module uart_rr_pick
  import uart_arb_defs::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    pointer,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    index,
  output logic             any
);

  // Walk from the farthest offset down so the nearest request overrides.
  always_comb begin
    int p;
    p      = 0;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      p = int'(pointer) + k;
      if (p >= N_REQ) p = p - N_REQ;
      if (req[p]) begin
        onehot    = '0;
        onehot[p] = 1'b1;
        index     = PW'(p);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among N_REQ byte producers.
// Optional watchdog on the WAIT state: define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_defs::*;
#(
  parameter int N_REQ          = 4,
  parameter int DBIT           = DBIT_DEFAULT,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DBIT-1:0] req_data,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      grant,
  output logic                  tx_start,
  output logic [DBIT-1:0]       tx_din,
  input  logic                  tx_done_tick,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int PW = clog2(N_REQ);

  state_t           state, state_next;
  logic [PW-1:0]    pointer;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    next_ptr;
  logic [N_REQ-1:0] grant_reg;
  logic [DBIT-1:0]  data_reg;
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             timeout_hit;
  logic             wait_exit;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req     (req),
    .pointer (pointer),
    .onehot  (pick_onehot),
    .index   (pick_idx),
    .any     (pick_any)
  );

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  // Held at zero outside WAIT, so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wd_cnt <= '0;
    else if (state != WAIT)   wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) && !tx_done_tick;
`else
  // No watchdog: the timeout parameter is accepted but has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  assign wait_exit = tx_done_tick | timeout_hit;
  assign next_ptr  = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (wait_exit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture on arbitration; grant_reg clears on the way back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pointer   <= '0;
      win_idx   <= '0;
      grant_reg <= '0;
      data_reg  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_any) begin
            data_reg  <= req_data[pick_idx*DBIT +: DBIT];
            grant_reg <= pick_onehot;
            win_idx   <= pick_idx;
          end
        end
        WAIT: begin
          if (wait_exit) begin
            pointer   <= next_ptr;
            grant_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign tx_start    = (state == START);
  assign ack         = (state == START) ? grant_reg : '0;
  assign grant       = grant_reg;
  assign tx_din      = data_reg;
  assign err_timeout = timeout_hit;

endmodule
